// File: rtl/wb_timer_if.sv
// Wishbone B4 pipelined bus bundle shared by the SoC interconnect and its slaves.
// Ports:
//   clk, rst  bus-level clock and reset (slaves may use their own instead)
// Signals:
//   cyc, stb, we, adr[31:0], sel[3:0], dat_m[31:0]   master -> slave
//   dat_s[31:0], ack, stall, err                      slave -> master
interface wb_if (
  input logic clk,
  input logic rst
);
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        stall;
  logic        err;

  modport master (
    input  clk, rst, dat_s, ack, stall, err,
    output cyc, stb, we, adr, sel, dat_m
  );

  modport slave (
    input  clk, rst, cyc, stb, we, adr, sel, dat_m,
    output dat_s, ack, stall, err
  );
endinterface

// File: rtl/wb_timer.sv
// RISC-V machine timer (mtime / mtimecmp) on the Wishbone bus, producing the
// level-sensitive machine timer interrupt for the core.
// Ports:
//   clk        system clock; all logic runs on it
//   rst        synchronous, active-high reset
//   wb         Wishbone B4 pipelined slave (cyc/stb/we/adr/sel/dat_m in,
//              dat_s/ack/stall/err out); the bundle's own clk/rst are unused
//   irq_timer  registered (mtime >= mtimecmp), active-high level
// Register map (byte offset inside the window):
//   0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI,
//   0x10 CTRL {PRESCALE[15:8], EN[0]}, 0x14 MTIME_HI_SNAP (read-only)
module wb_timer #(
  parameter logic [7:0] PRESCALE_RESET = 8'd99,
  parameter int         ADDR_WIDTH     = 12
) (
  input  logic clk,
  input  logic rst,
  wb_if.slave  wb,
  output logic irq_timer
);

  localparam logic [2:0] REG_MTIME_LO = 3'd0;
  localparam logic [2:0] REG_MTIME_HI = 3'd1;
  localparam logic [2:0] REG_CMP_LO   = 3'd2;
  localparam logic [2:0] REG_CMP_HI   = 3'd3;
  localparam logic [2:0] REG_CTRL     = 3'd4;
  localparam logic [2:0] REG_SNAP     = 3'd5;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        en;
  logic [7:0]  prescale;
  logic [7:0]  pre_cnt;
  logic [31:0] snap;

  logic        ack_q;
  logic        err_q;
  logic [31:0] dat_q;

  logic [ADDR_WIDTH-1:0] off;
  logic [2:0]            idx;
  logic                  req;
  logic                  hit;
  logic                  wr;
  logic                  rd;
  logic                  tick;
  logic [31:0]           ctrl_val;
  logic [31:0]           ctrl_new;
  logic [31:0]           rd_data;

  // Window-external address bits and the bundle's clock/reset carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{wb.clk, wb.rst, wb.adr[31:ADDR_WIDTH]};

  // Replace only the byte lanes selected by sel.
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] val,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) res[8*i +: 8] = val[8*i +: 8];
    end
    return res;
  endfunction

  // Address decode: only word-aligned offsets 0x00..0x14 are backed by a register;
  // everything else in the window answers with err.
  always_comb begin
    req      = wb.cyc & wb.stb;
    off      = wb.adr[ADDR_WIDTH-1:0];
    idx      = off[4:2];
    hit      = (off[ADDR_WIDTH-1:5] == '0) && (off[1:0] == 2'b00) && (idx <= REG_SNAP);
    wr       = req & hit & wb.we;
    rd       = req & hit & ~wb.we;
    tick     = en && (pre_cnt == prescale);
    ctrl_val = {16'h0000, prescale, 7'h00, en};
    ctrl_new = merge_bytes(ctrl_val, wb.dat_m, wb.sel);
    rd_data  = '0;
    case (idx)
      REG_MTIME_LO: rd_data = mtime[31:0];
      REG_MTIME_HI: rd_data = mtime[63:32];
      REG_CMP_LO:   rd_data = mtimecmp[31:0];
      REG_CMP_HI:   rd_data = mtimecmp[63:32];
      REG_CTRL:     rd_data = ctrl_val;
      REG_SNAP:     rd_data = snap;
      default:      rd_data = '0;
    endcase
  end

  // Bus response: one ack or err per accepted request, one cycle later; read data
  // is captured from the register values present when the request was seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req & hit;
      err_q <= req & ~hit;
      dat_q <= rd ? rd_data : '0;
    end
  end

  // Control register and prescaler. A write touching the PRESCALE byte restarts
  // the count so the new period starts cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      en       <= 1'b1;
      prescale <= PRESCALE_RESET;
      pre_cnt  <= '0;
    end else begin
      if (wr && idx == REG_CTRL) begin
        en       <= ctrl_new[0];
        prescale <= ctrl_new[15:8];
      end
      if (wr && idx == REG_CTRL && wb.sel[1]) begin
        pre_cnt <= '0;
      end else if (tick) begin
        pre_cnt <= '0;
      end else if (en) begin
        pre_cnt <= pre_cnt + 8'd1;
      end
    end
  end

  // mtime: a bus write to either half takes priority over the tick, so software
  // sees exactly the value it wrote. The snapshot captures the upper half whenever
  // the lower half is read, giving a tear-free 64-bit read.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime    <= '0;
      mtimecmp <= '1;
      snap     <= '0;
    end else begin
      if (wr && idx == REG_MTIME_LO) begin
        mtime[31:0] <= merge_bytes(mtime[31:0], wb.dat_m, wb.sel);
      end else if (wr && idx == REG_MTIME_HI) begin
        mtime[63:32] <= merge_bytes(mtime[63:32], wb.dat_m, wb.sel);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end
      if (wr && idx == REG_CMP_LO) begin
        mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], wb.dat_m, wb.sel);
      end
      if (wr && idx == REG_CMP_HI) begin
        mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wb.dat_m, wb.sel);
      end
      if (rd && idx == REG_MTIME_LO) begin
        snap <= mtime[63:32];
      end
    end
  end

  // Interrupt compares the current register contents every cycle, independent of EN.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_timer <= 1'b0;
    end else begin
      irq_timer <= (mtime >= mtimecmp);
    end
  end

  assign wb.ack   = ack_q;
  assign wb.err   = err_q;
  assign wb.dat_s = dat_q;
  assign wb.stall = 1'b0;

endmodule
